// File: rtl/vdp_clk_reset_seq.sv
// Clock/reset sequencer for the VDP: synchronizes PLL lock, holds reset until lock has been
// stable, then generates clk/4 and clk/24 enables. Optional macro: VDP_LOCK_LOSS_RESET_EN.
module vdp_clk_reset_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_lock,
  output logic sys_reset_n,
  output logic ready,
  output logic ce_div4,
  output logic ce_div24
);

  localparam int unsigned CntW = $clog2(LOCK_STABLE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_STABLE_CYCLES - 1);

  // RUN is the only encoding with bit 1 set, so the reset decode is a single flop output.
  typedef enum logic [1:0] {
    StWaitLock = 2'b00,
    StStable   = 2'b01,
    StRun      = 2'b10
  } state_e;

  state_e            state_q;
  logic              lock_m_q;
  logic              lock_s_q;
  logic [CntW-1:0]   stable_cnt_q;
  logic [4:0]        div_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      lock_m_q <= pll_lock;
      lock_s_q <= lock_m_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StWaitLock;
      stable_cnt_q <= '0;
    end else begin
      case (state_q)
        StWaitLock: begin
          if (lock_s_q) begin
            state_q      <= StStable;
            stable_cnt_q <= '0;
          end
        end
        StStable: begin
          // A drop on the terminal-count cycle still counts as a failure.
          if (!lock_s_q) begin
            state_q <= StWaitLock;
          end else if (stable_cnt_q == CntLast) begin
            state_q <= StRun;
          end else begin
            stable_cnt_q <= stable_cnt_q + CntW'(1);
          end
        end
        StRun: begin
`ifdef VDP_LOCK_LOSS_RESET_EN
          if (!lock_s_q) begin
            state_q <= StWaitLock;
          end
`endif
        end
        default: state_q <= StWaitLock;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || (state_q != StRun)) begin
      div_cnt_q <= 5'd0;
    end else if (div_cnt_q == 5'd23) begin
      div_cnt_q <= 5'd0;
    end else begin
      div_cnt_q <= div_cnt_q + 5'd1;
    end
  end

  assign sys_reset_n = state_q[1];
  assign ready       = state_q[1];
  assign ce_div4     = state_q[1] && (div_cnt_q[1:0] == 2'd3);
  assign ce_div24    = state_q[1] && (div_cnt_q == 5'd23);

endmodule

// File: tb/tb_vdp_clk_reset_seq.sv
// Self-checking bench for vdp_clk_reset_seq (LOCK_STABLE_CYCLES=16) with a cycle-level
// model based on lock streak length and RUN cycle count.
module tb_vdp_clk_reset_seq;

  localparam int N = 16;
  localparam int Latency = N + 3;

  logic clk;
  logic reset_n;
  logic pll_lock;
  logic sys_reset_n;
  logic ready;
  logic ce_div4;
  logic ce_div24;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic m_p1, m_p2;
  logic m_run;
  int   m_streak;
  int   m_runcyc;

  vdp_clk_reset_seq #(
    .LOCK_STABLE_CYCLES(N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_lock   (pll_lock),
    .sys_reset_n(sys_reset_n),
    .ready      (ready),
    .ce_div4    (ce_div4),
    .ce_div24   (ce_div24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, take one clock edge, advance the model, then settle 1 time unit.
  task automatic tick(input logic rn, input logic pl);
    logic ls;
    reset_n  = rn;
    pll_lock = pl;
    @(posedge clk);
    if (!rn) begin
      m_p1 = 1'b0; m_p2 = 1'b0; m_run = 1'b0; m_streak = 0; m_runcyc = 0;
    end else begin
      ls = m_p2;
      if (m_run) begin
`ifdef VDP_LOCK_LOSS_RESET_EN
        if (!ls) begin
          m_run = 1'b0; m_runcyc = 0; m_streak = 0;
        end else begin
          m_runcyc++;
        end
`else
        m_runcyc++;
`endif
      end else begin
        m_streak = ls ? m_streak + 1 : 0;
        // Lock must be seen in WAIT_LOCK plus N STABLE cycles.
        if (m_streak == N + 1) begin
          m_run = 1'b1; m_runcyc = 1; m_streak = 0;
        end
      end
      m_p2 = m_p1;
      m_p1 = pl;
    end
    #1;
  endtask

  // Raise lock and count edges until release; -1 if it never comes.
  task automatic measure_release(output int lat);
    lat = -1;
    for (int e = 1; e <= 60; e++) begin
      tick(1'b1, 1'b1);
      if (sys_reset_n === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic bring_up(output int lat);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    measure_release(lat);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      n_cmp++;
      if ({sys_reset_n, ready, ce_div4, ce_div24} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 0000", i,
                 {sys_reset_n, ready, ce_div4, ce_div24});
      end
    end
  endtask

  task automatic test_lock_latency();
    int lat, first4, first24;
    bring_up(lat);
    n_cmp++;
    if (lat !== Latency) begin
      n_bad++;
      $display("FAIL lock_latency: got %0d expected %0d", lat, Latency);
    end
    first4 = -1;
    first24 = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) tick(1'b1, 1'b1);
      if (ce_div4 === 1'b1 && first4 < 0) first4 = c;
      if (ce_div24 === 1'b1 && first24 < 0) first24 = c;
      n_cmp++;
      if (ce_div4 !== ((c % 4) == 0) || ce_div24 !== ((c % 24) == 0) || ready !== 1'b1) begin
        n_bad++;
        $display("FAIL run_cadence cycle %0d: got ce4=%b ce24=%b ready=%b expected %b %b 1",
                 c, ce_div4, ce_div24, ready, (c % 4) == 0, (c % 24) == 0);
      end
    end
    n_cmp++;
    if (first4 != 4) begin
      n_bad++;
      $display("FAIL first_ce_div4: got %0d expected 4", first4);
    end
    n_cmp++;
    if (first24 != 24) begin
      n_bad++;
      $display("FAIL first_ce_div24: got %0d expected 24", first24);
    end
  endtask

  task automatic test_stable_drop();
    int lat;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 13; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      n_cmp++;
      if (sys_reset_n !== 1'b0) begin
        n_bad++;
        $display("FAIL stable_drop_held: got %b expected 0", sys_reset_n);
      end
    end
    measure_release(lat);
    n_cmp++;
    if (lat !== Latency) begin
      n_bad++;
      $display("FAIL stable_drop_relatency: got %0d expected %0d", lat, Latency);
    end
  endtask

  task automatic test_run_lock_loss();
    int lat, first_low;
    bring_up(lat);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    first_low = -1;
    for (int d = 1; d <= 5; d++) begin
      tick(1'b1, 1'b0);
      if (sys_reset_n === 1'b0 && first_low < 0) first_low = d;
      n_cmp++;
      if (ce_div4 !== (m_run && (m_runcyc % 4 == 0)) || ready !== sys_reset_n) begin
        n_bad++;
        $display("FAIL lock_loss_outputs edge %0d: got ce4=%b ready=%b expected %b %b", d,
                 ce_div4, ready, m_run && (m_runcyc % 4 == 0), sys_reset_n);
      end
    end
`ifdef VDP_LOCK_LOSS_RESET_EN
    n_cmp++;
    if (first_low != 3) begin
      n_bad++;
      $display("FAIL lock_loss_drop_edge: got %0d expected 3", first_low);
    end
    measure_release(lat);
    n_cmp++;
    if (lat !== Latency) begin
      n_bad++;
      $display("FAIL lock_loss_relatency: got %0d expected %0d", lat, Latency);
    end
`else
    n_cmp++;
    if (first_low != -1) begin
      n_bad++;
      $display("FAIL lock_loss_ignored: got drop at edge %0d expected none", first_low);
    end
    tick(1'b1, 1'b1);
    n_cmp++;
    if (sys_reset_n !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_loss_still_run: got %b expected 1", sys_reset_n);
    end
`endif
  endtask

  task automatic test_reset_pulse();
    int lat;
    bring_up(lat);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    n_cmp++;
    if ({sys_reset_n, ready, ce_div4, ce_div24} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_pulse_low: got %b expected 0000",
               {sys_reset_n, ready, ce_div4, ce_div24});
    end
    measure_release(lat);
    n_cmp++;
    if (lat !== Latency) begin
      n_bad++;
      $display("FAIL reset_pulse_relatency: got %0d expected %0d", lat, Latency);
    end
  endtask

  task automatic test_ce_window();
    int lat, cnt4, cnt24, first24, dbl;
    logic prev4, prev24;
    bring_up(lat);
    cnt4 = 0; cnt24 = 0; first24 = -1; dbl = 0;
    prev4 = 1'b0; prev24 = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if (c > 1) tick(1'b1, 1'b1);
      if (ce_div4 === 1'b1) cnt4++;
      if (ce_div24 === 1'b1) begin
        cnt24++;
        if (first24 < 0) first24 = c;
      end
      if ((prev4 && ce_div4) || (prev24 && ce_div24)) dbl++;
      prev4 = ce_div4;
      prev24 = ce_div24;
    end
    n_cmp++;
    if (cnt4 != 250) begin
      n_bad++;
      $display("FAIL window_ce_div4_count: got %0d expected 250", cnt4);
    end
    n_cmp++;
    if (cnt24 != 41) begin
      n_bad++;
      $display("FAIL window_ce_div24_count: got %0d expected 41", cnt24);
    end
    n_cmp++;
    if (first24 != 24) begin
      n_bad++;
      $display("FAIL window_first_ce_div24: got %0d expected 24", first24);
    end
    n_cmp++;
    if (dbl != 0) begin
      n_bad++;
      $display("FAIL window_back_to_back: got %0d double pulses expected 0", dbl);
    end
  endtask

  task automatic test_random();
    int remaining;
    logic pl, rn, e_ce4, e_ce24;
    remaining = 0;
    pl = 1'b0;
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if (remaining == 0) begin
        pl = ($urandom_range(0, 2) != 0);
        remaining = pl ? $urandom_range(1, 60) : $urandom_range(1, 4);
      end
      remaining--;
      rn = ($urandom_range(0, 199) != 0);
      tick(rn, pl);
      e_ce4  = m_run && (m_runcyc % 4 == 0);
      e_ce24 = m_run && (m_runcyc % 24 == 0);
      n_cmp++;
      if (sys_reset_n !== m_run || ready !== m_run || ce_div4 !== e_ce4 ||
          ce_div24 !== e_ce24) begin
        n_bad++;
        $display("FAIL random cycle %0d: got rst=%b rdy=%b ce4=%b ce24=%b expected %b %b %b %b",
                 i, sys_reset_n, ready, ce_div4, ce_div24, m_run, m_run, e_ce4, e_ce24);
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    test_reset();
    test_lock_latency();
    test_stable_drop();
    test_run_lock_loss();
    test_reset_pulse();
    test_ce_window();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
